// File: rtl/rotate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_ctrl_pkg
//  Description : Shared encodings for the rotate command sequencer. Holds the
//                host op codes, the datapath ctrl codes and the FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package rotate_ctrl_pkg;

  // Host command op codes
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ROR  = 2'b01;
  localparam logic [1:0] OP_ROL  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // Datapath ctrl codes understood by univ_rotate_reg
  localparam logic [1:0] CTL_LOAD = 2'b00;
  localparam logic [1:0] CTL_ROR  = 2'b01;
  localparam logic [1:0] CTL_ROL  = 2'b10;
  localparam logic [1:0] CTL_HOLD = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/univ_rotate_reg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_rotate_reg
//  Description : DW-bit register that loads, rotates right, rotates left by
//                one bit, or holds, as selected by ctrl each clock.
//  Revision    : 1.0  initial release
// ============================================================================
module univ_rotate_reg
  import rotate_ctrl_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic [1:0]    ctrl,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  logic [DW-1:0] r_q;

  // One register operation per clock; reset clears the contents
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_q <= '0;
    end else begin
      case (ctrl)
        CTL_LOAD: r_q <= data;
        CTL_ROR:  r_q <= {r_q[0], r_q[DW-1:1]};
        CTL_ROL:  r_q <= {r_q[DW-2:0], r_q[DW-1]};
        default:  r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/rotate_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_seq_ctrl
//  Description : Command sequencer for one univ_rotate_reg. Accepts LOAD,
//                rotate-by-N and NOP commands over valid/ready, steps the
//                register one operation per clock and pulses done when q is
//                final.
//  Options     : SHORTEST_PATH_EN - rotates longer than DW/2 are replaced at
//                accept by the opposite direction with amount DW-N.
//  Revision    : 1.0  initial release
// ============================================================================
module rotate_seq_ctrl
  import rotate_ctrl_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_amt,
  input  logic [DW-1:0] cmd_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_op;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_data;
  logic [1:0]    w_ctrl;
  logic          w_accept;
  logic          w_is_rot;
  logic [1:0]    w_op_eff;
  logic [AW-1:0] w_amt_eff;

  // Reset masks ready so a command presented with reset is never taken
  assign cmd_ready = (r_state == ST_IDLE) & ~sync_rst;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_is_rot  = (cmd_op == OP_ROR) || (cmd_op == OP_ROL);

`ifdef SHORTEST_PATH_EN
  // Swap direction for long rotates; the final q is the same either way
  always_comb begin
    w_op_eff  = cmd_op;
    w_amt_eff = cmd_amt;
    if (w_is_rot && (int'(cmd_amt) > DW / 2)) begin
      w_op_eff  = (cmd_op == OP_ROL) ? OP_ROR : OP_ROL;
      w_amt_eff = AW'(DW - int'(cmd_amt));
    end
  end
`else
  assign w_op_eff  = cmd_op;
  assign w_amt_eff = cmd_amt;
`endif

  // Capture the op and load data at the accept edge
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_op   <= OP_NOP;
      r_data <= '0;
    end else if (w_accept) begin
      r_op   <= w_op_eff;
      r_data <= cmd_data;
    end
  end

  // Step counter: loaded with the amount, counts down while rotating, stops at zero
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_amt_eff;
    end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - AW'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath ctrl; the register holds outside LOAD and RUN
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = CTL_HOLD;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_LOAD) begin
            w_state_nxt = ST_LOAD;
          end else if (w_is_rot && (cmd_amt != '0)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        w_ctrl      = CTL_LOAD;
        w_state_nxt = ST_DONE;
      end
      ST_RUN: begin
        w_ctrl = (r_op == OP_ROL) ? CTL_ROL : CTL_ROR;
        if (r_cnt <= AW'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign done = (r_state == ST_DONE);
  assign busy = (r_state != ST_IDLE);

  univ_rotate_reg #(
    .DW (DW)
  ) u_reg (
    .clk      (clk),
    .sync_rst (sync_rst),
    .ctrl     (w_ctrl),
    .data     (r_data),
    .q        (q)
  );

endmodule
`default_nettype wire
